contador: RTL and testbench
===========================

CONTADOR -- requirements
Module: contador

Interface
REQ-001 Parameter WIDTH, default 26, SHALL set the counter width in bits.
REQ-002 Parameter MAX_COUNT, default 2**WIDTH-1, SHALL set the highest count value before wrap.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 en  input  1  SHALL be the count enable; the system ties it to 1 for free-running use.
REQ-006 dir  input  1  SHALL select the count direction: 0 = up, 1 = down.
REQ-007 load  input  1  SHALL be the synchronous load strobe.
REQ-008 load_value  input  WIDTH  SHALL be the value captured on load.
REQ-009 data  output  WIDTH  SHALL be the registered count value.
REQ-010 tc  output  1  SHALL be the registered terminal-count (wrap) pulse.

Function
REQ-011 data SHALL be a register driven directly by a flop, with no combinational path from any input.
REQ-012 With en=1 and dir=0, data SHALL increment by exactly 1 on every rising clk edge, with the new value visible before the next falling edge.
  - From 0, data SHALL read 1 after the first edge, 2 after the second, and so on.
REQ-013 Up-count wrap: when data=MAX_COUNT and an up-count occurs, data SHALL become 0.
  - On that same edge, tc SHALL be 1 for exactly one cycle.
REQ-014 Down-count wrap: when data=0 and a down-count occurs, data SHALL become MAX_COUNT.
  - On that same edge, tc SHALL be 1 for exactly one cycle.
REQ-015 With en=0, data SHALL hold its value and tc SHALL be 0.
REQ-016 Priority SHALL be rst > load > en count > hold.
REQ-017 Load (when compiled in, see REQ-024) SHALL set data to load_value on the edge where load=1, regardless of en.
  - tc SHALL be 0 on a load cycle.
REQ-018 A load_value above MAX_COUNT SHALL be clamped to MAX_COUNT.
REQ-019 Arithmetic SHALL be unsigned, modulo (MAX_COUNT+1), with no overflow beyond WIDTH bits.
REQ-020 tc SHALL be 0 in every cycle except wrap cycles.

Reset
REQ-021 Asserting rst SHALL immediately force data=0 and tc=0, without waiting for a clock edge.
REQ-022 While rst=1, data SHALL stay 0.
  - The first rising edge after rst deasserts with en=1, dir=0 SHALL produce data=1.
REQ-023 The data and tc registers SHALL also power up (time 0) at 0, so an unreset free-running instance reads data=0 before its first clk edge.
  - A reset asserted mid-count SHALL discard the current count.

Configuration
REQ-024 Macro CONTADOR_LOAD_EN SHALL control the load feature.
  - When defined: load and load_value SHALL function as specified in REQ-017/REQ-018.
  - When undefined: the ports SHALL still exist but SHALL be ignored, so data changes only by reset or counting.

Verification
REQ-025 No rst, en=1, dir=0, 2-unit clock period:
  - data SHALL be 0 at t=0.5.
  - data SHALL equal N at the N-th falling edge, with zero mismatches over 100 cycles.
REQ-026 Preload data=MAX_COUNT (0x3FFFFFF) via load, then one up-count edge -> data=0 and tc=1 for that cycle only.
REQ-027 dir=1 from data=0, one edge -> data=0x3FFFFFF and tc=1.
  - Next edge -> data=0x3FFFFFE and tc=0.
REQ-028 Count to 37, assert rst between clock edges -> data=0 immediately.
  - Release rst -> data=1 after the next edge.
REQ-029 en=0 for 5 edges at data=12 -> data stays 12 and tc=0.
  - Simultaneous load=1 with load_value=500 (macro defined) -> data=500.
  - Same stimulus with macro undefined -> data stays 12.

Source files
------------

// File: rtl/contador.sv
// contador: WIDTH-bit up/down wrap-around counter with a registered
// terminal-count pulse and an optional synchronous load.
//
// Build option: define CONTADOR_LOAD_EN to enable the load/load_value
// path. When it is undefined the load ports remain on the interface,
// but they are ignored, so data changes only by reset or by counting.
//
// Behaviour summary:
//   - Priority is rst > load > count (en) > hold.
//   - The count wraps modulo MAX_COUNT+1 in both directions.
//   - tc is high only for the cycle that follows a wrap edge.
//   - data and tc come straight from flops and power up at zero, so a
//     free-running instance that never sees rst still starts from 0.
module contador #(
  parameter int unsigned      WIDTH     = 26,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] data,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  // State registers. The declaration initialisers supply the power-up
  // value of zero; rst gives the same value at run time.
  logic [WIDTH-1:0] count_reg = '0;
  logic             tc_reg    = 1'b0;

  // Next-state values produced by the combinational block below.
  logic [WIDTH-1:0] count_next;
  logic             tc_next;

  // Gated load strobe and the value to load. Both are fixed to inactive
  // values when the load feature is not compiled in.
  logic             load_active;
  logic [WIDTH-1:0] load_target;

`ifdef CONTADOR_LOAD_EN
  // Load path enabled: clamp an out-of-range value to the top of the range.
  assign load_active = load;
  assign load_target = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
`else
  // Load path disabled: the ports stay on the interface but have no effect.
  logic unused_load_ports;
  assign unused_load_ports = ^{load, load_value};
  assign load_active       = 1'b0;
  assign load_target       = ZERO;
`endif

  // Next-state selection: load takes priority over counting, and a wrap
  // in either direction raises tc for the cycle that follows.
  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    if (load_active) begin
      count_next = load_target;
    end else if (en) begin
      if (dir) begin
        // Down count.
        if (count_reg == ZERO) begin
          count_next = MAX_COUNT;
          tc_next    = 1'b1;
        end else begin
          count_next = count_reg - ONE;
        end
      end else begin
        // Up count. Using >= means a value above MAX_COUNT still wraps.
        if (count_reg >= MAX_COUNT) begin
          count_next = ZERO;
          tc_next    = 1'b1;
        end else begin
          count_next = count_reg + ONE;
        end
      end
    end
  end

  // Count and terminal-count registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      tc_reg    <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
    end
  end

  // The outputs are direct copies of the flops.
  assign data = count_reg;
  assign tc   = tc_reg;

endmodule

// File: tb/tb_contador.sv
// tb_contador: directed and random checks of contador, with the default
// parameters, against a modular-arithmetic reference model.
// The load expectations follow CONTADOR_LOAD_EN in the same way as the RTL.
`timescale 1ns/100ps
module tb_contador;

  localparam int unsigned W    = 26;
  localparam longint      MAXL = 64'h3FF_FFFF;
  localparam logic [W-1:0] MAXV = 26'h3FF_FFFF;
`ifdef CONTADOR_LOAD_EN
  localparam bit LOAD_ON = 1'b1;
`else
  localparam bit LOAD_ON = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         en;
  logic         dir;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] data;
  logic         tc;

  int vectors;
  int miscompares;

  // Reference model state: the count as a plain integer in
  // [0, MAXL], plus the expected tc value.
  longint model_count;
  bit     model_tc;

  contador dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dir        (dir),
    .load       (load),
    .load_value (load_value),
    .data       (data),
    .tc         (tc)
  );

  // 2 ns clock period, with rising edges at t = 1, 3, 5, ...
  initial clk = 1'b0;
  always #1 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one rising edge.
  task automatic model_edge(input bit e, input bit d, input bit l,
                            input logic [W-1:0] lv);
    longint raw;
    if (l && LOAD_ON) begin
      model_count = (longint'(lv) > MAXL) ? MAXL : longint'(lv);
      model_tc    = 1'b0;
    end else if (e) begin
      raw         = model_count + (d ? -64'sd1 : 64'sd1);
      model_tc    = (raw < 0) || (raw > MAXL);
      model_count = ((raw % (MAXL + 1)) + (MAXL + 1)) % (MAXL + 1);
    end else begin
      model_tc = 1'b0;
    end
  endtask

  // Apply one set of inputs just after a falling edge. Let the next
  // rising edge happen, then check at the following falling edge.
  task automatic step(input string tag, input bit e, input bit d,
                      input bit l, input logic [W-1:0] lv);
    en         = e;
    dir        = d;
    load       = l;
    load_value = lv;
    @(negedge clk);
    model_edge(e, d, l, lv);
    $display("[%0t] %s en=%0d dir=%0d load=%0d lv=%0h -> data=%0h tc=%0d",
             $time, tag, e, d, l, lv, data, tc);
    check({tag, "_data"}, data, model_count[W-1:0]);
    check({tag, "_tc"}, {{(W-1){1'b0}}, tc}, {{(W-1){1'b0}}, model_tc});
  endtask

  // Assert rst between clock edges (called just after a falling edge),
  // check that the clear is immediate, hold rst for one full edge, then
  // release it.
  task automatic async_reset(input string tag);
    en   = 1'b1;
    dir  = 1'b0;
    load = 1'b0;
    #0.5 rst = 1'b1;
    #0.1;
    model_count = 0;
    model_tc    = 1'b0;
    $display("[%0t] %s rst asserted -> data=%0h tc=%0d", $time, tag, data, tc);
    check({tag, "_rst_now_data"}, data, '0);
    check({tag, "_rst_now_tc"}, {{(W-1){1'b0}}, tc}, '0);
    @(negedge clk);
    check({tag, "_rst_hold_data"}, data, '0);
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    en          = 1'b1;
    dir         = 1'b0;
    load        = 1'b0;
    load_value  = '0;
    model_count = 0;
    model_tc    = 1'b0;

    // Power-up value without any reset.
    #0.5;
    $display("[%0t] powerup data=%0h tc=%0d", $time, data, tc);
    check("powerup_data", data, '0);
    check("powerup_tc", {{(W-1){1'b0}}, tc}, '0);

    // Free-running count: data equals N at the N-th falling edge.
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      $display("[%0t] freerun n=%0d data=%0h tc=%0d", $time, n, data, tc);
      check("freerun_data", data, W'(n));
      check("freerun_tc", {{(W-1){1'b0}}, tc}, '0);
    end
    model_count = 100;

    // Reset in the middle of a count: clear, then count from 1 again.
    async_reset("clear");
    for (int n = 0; n < 37; n++) step("to37", 1'b1, 1'b0, 1'b0, '0);
    check("at37", data, W'(37));
    async_reset("mid");
    step("after_rst", 1'b1, 1'b0, 1'b0, '0);
    check("after_rst_one", data, W'(1));

    // Down-count wrap from 0, followed by an ordinary decrement.
    async_reset("dn");
    step("dn_wrap", 1'b1, 1'b1, 1'b0, '0);
    check("dn_wrap_max", data, MAXV);
    step("dn_next", 1'b1, 1'b1, 1'b0, '0);

    // Preload MAX (only honoured when load is built in; otherwise the
    // count steps from MAX-1 to MAX), then wrap upward and check the
    // tc pulse lasts one cycle.
    step("preload", 1'b1, 1'b0, 1'b1, MAXV);
    check("preload_max", data, MAXV);
    step("up_wrap", 1'b1, 1'b0, 1'b0, '0);
    check("up_wrap_zero", data, '0);
    step("up_after", 1'b1, 1'b0, 1'b0, '0);

    // Hold at 12 with en=0, then load 500 while still disabled.
    async_reset("hold");
    for (int n = 0; n < 12; n++) step("to12", 1'b1, 1'b0, 1'b0, '0);
    for (int n = 0; n < 5; n++) step("hold12", 1'b0, 1'b0, 1'b0, '0);
    check("hold12_data", data, W'(12));
    step("load500", 1'b0, 1'b0, 1'b1, W'(500));
    check("load500_data", data, LOAD_ON ? W'(500) : W'(12));

    // Random mix of enable, direction, load and reset.
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] lv;
      int           pick;
      pick = int'($urandom_range(0, 3));
      lv   = (pick == 0) ? MAXV : (pick == 1) ? W'($urandom_range(0, 3))
                                               : W'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step("rnd", $urandom_range(0, 3) != 0, 1'($urandom),
             $urandom_range(0, 7) == 0, lv);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
